// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
package timer_pkg;

  // One BCD digit, 0..9 in normal use.
  typedef logic [3:0] bcdDigit;

  // Countdown controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } timerState;

  // Largest legal value of the seconds-tens digit and of any other digit.
  localparam bcdDigit SEC_TENS_MAX = 4'd5;
  localparam bcdDigit DIGIT_MAX    = 4'd9;

  // Wrap value of digit position idx (0=us, 1=ds, 2=um, 3=dm).
  function automatic bcdDigit digitWrap(input int idx);
    return (idx == 1) ? SEC_TENS_MAX : DIGIT_MAX;
  endfunction

  // Clamp an out-of-range preset digit to its legal maximum.
  function automatic bcdDigit satDigit(input bcdDigit d, input bcdDigit lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD down-counter digit with synchronous load and borrow-out.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter bcdDigit WRAP = DIGIT_MAX
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  bcdDigit loadVal,
  input  logic    dec,
  output bcdDigit digit,
  output logic    borrowOut
);

  // Load wins over decrement; a decrement from 0 wraps and borrows upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= loadVal;
    end else if (dec) begin
      digit <= (digit == 4'd0) ? WRAP : digit - 4'd1;
    end
  end

  assign borrowOut = dec && (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_mmss.sv
// MM:SS countdown: loads sanitised BCD presets on start, decrements once per
// second through a borrow chain of digit counters, drives the valve while
// counting and pulses done when 00:00 is reached.
module bcd_countdown_mmss
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PRESC_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [3:0] preset_us,
  input  logic [3:0] preset_ds,
  input  logic [3:0] preset_um,
  input  logic [3:0] preset_dm,
  output logic [3:0] us,
  output logic [3:0] ds,
  output logic [3:0] um,
  output logic [3:0] dm,
  output logic       valve,
  output logic       busy,
  output logic       done
);

  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  timerState          stateReg, stateNext;
  logic [PRESC_W-1:0] prescReg, prescNext;

  bcdDigit presetArr [4];
  bcdDigit saneArr   [4];
  bcdDigit loadVal   [4];
  bcdDigit digitVal  [4];
  logic [4:0] decChain;   // decChain[i] decrements digit i; [4] is dm underflow

  logic digitLoad;
  logic clearDigits;
  logic tick;
  logic presetsZero;
  logic atOne;

  assign presetArr[0] = preset_us;
  assign presetArr[1] = preset_ds;
  assign presetArr[2] = preset_um;
  assign presetArr[3] = preset_dm;

  assign decChain[0] = tick;

  // Per-digit sanitising, load mux and borrow-chained down-counter.
  for (genvar gi = 0; gi < 4; gi++) begin : gDigit
    assign saneArr[gi] = satDigit(presetArr[gi], digitWrap(gi));
    assign loadVal[gi] = clearDigits ? 4'd0 : saneArr[gi];

    bcd_digit_down #(
      .WRAP(digitWrap(gi))
    ) uDigit (
      .clk      (clk),
      .rst      (rst),
      .load     (digitLoad),
      .loadVal  (loadVal[gi]),
      .dec      (decChain[gi]),
      .digit    (digitVal[gi]),
      .borrowOut(decChain[gi+1])
    );
  end

  assign presetsZero = (saneArr[0] == 4'd0) && (saneArr[1] == 4'd0) &&
                       (saneArr[2] == 4'd0) && (saneArr[3] == 4'd0);

  // The decrement that lands on 00:00 is the one taken from 00:01.
  assign atOne = (digitVal[0] == 4'd1) && (digitVal[1] == 4'd0) &&
                 (digitVal[2] == 4'd0) && (digitVal[3] == 4'd0);

  assign us = digitVal[0];
  assign ds = digitVal[1];
  assign um = digitVal[2];
  assign dm = digitVal[3];

  // Next-state, prescaler and digit-load decisions; abort beats pause beats tick.
  always_comb begin
    stateNext   = stateReg;
    prescNext   = prescReg;
    digitLoad   = 1'b0;
    clearDigits = 1'b0;
    tick        = 1'b0;
    unique case (stateReg)
      IDLE: begin
        if (start && !abort) begin
          digitLoad = 1'b1;
          prescNext = '0;
          stateNext = presetsZero ? FINISH : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          digitLoad   = 1'b1;
          clearDigits = 1'b1;
          stateNext   = IDLE;
        end else if (pause) begin
          stateNext = HOLD;
        end else if (prescReg == TICK_LAST) begin
          prescNext = '0;
          tick      = 1'b1;
          // An underflow out of dm cannot occur, but would also end the run.
          if (atOne || decChain[4]) begin
            stateNext = FINISH;
          end
        end else begin
          prescNext = prescReg + 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          digitLoad   = 1'b1;
          clearDigits = 1'b1;
          stateNext   = IDLE;
        end else if (!pause) begin
          stateNext = RUN;
        end
      end
      FINISH: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, prescaler and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      prescReg <= '0;
      valve    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      stateReg <= stateNext;
      prescReg <= prescNext;
      valve    <= (stateNext == RUN) || (stateNext == HOLD);
      busy     <= (stateNext != IDLE);
      done     <= (stateNext == FINISH);
    end
  end

endmodule
